// File: rtl/uart_receiver_fsm.sv
// UART receive stage: 2-FF input synchronizer, mid-bit sampling FSM, 8 data bits
// LSB first, optional even-parity slot, stop-bit check with break handling.
module uart_receiver_fsm #(
    parameter int CLK_HZ     = 50000000,
    parameter int BIT_9600   = CLK_HZ / 9600,
    parameter int BIT_19200  = CLK_HZ / 19200,
    parameter int BIT_38400  = CLK_HZ / 38400,
    parameter int BIT_57600  = CLK_HZ / 57600,
    parameter int BIT_115200 = CLK_HZ / 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxi,
    input  logic [2:0] BC,
    input  logic       PbitEna,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic [2:0]  state;
    logic        rx_meta;
    logic        rxs;
    logic [12:0] sel_len;
    logic [12:0] bit_len;
    logic        par_en;
    logic [12:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        perr;
    logic [12:0] half_last;
    logic [12:0] bit_last;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch.
    always_comb begin
        sel_len = 13'(BIT_9600);
        case (BC)
            3'b001:  sel_len = 13'(BIT_19200);
            3'b010:  sel_len = 13'(BIT_38400);
            3'b011:  sel_len = 13'(BIT_57600);
            3'b100:  sel_len = 13'(BIT_115200);
            default: sel_len = 13'(BIT_9600);
        endcase
    end

    assign half_last = (bit_len >> 1) - 13'd1;
    assign bit_last  = bit_len - 13'd1;
    assign Busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            bit_len   <= 13'(BIT_9600);
            par_en    <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            RxData    <= 8'h00;
            RxValid   <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            rx_meta <= Rxi;
            rxs     <= rx_meta;
            RxValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_len <= sel_len;
                        par_en  <= PbitEna;
                    end
                end
                START: begin
                    if (cnt == half_last) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (cnt == bit_last) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= par_en ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                PARITY: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        perr  <= rxs ^ (^shreg);
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a following start bit be caught.
                    if (cnt == bit_last) begin
                        cnt       <= '0;
                        RxData    <= shreg;
                        ParityErr <= par_en & perr;
                        FrameErr  <= ~rxs;
                        RxValid   <= 1'b1;
                        state     <= rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Self-checking bench for uart_receiver_fsm: bit-banged frames, scoreboard queue of
// expected {data, parity_err, frame_err}, strobe monitor on the falling clock edge.
module tb_uart_receiver_fsm;

    localparam int B9600   = 192;
    localparam int B19200  = 96;
    localparam int B38400  = 48;
    localparam int B57600  = 32;
    localparam int B115200 = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rxi;
    logic [2:0] BC;
    logic       PbitEna;
    logic [7:0] RxData;
    logic       RxValid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb[$];
    logic prev_valid = 1'b0;

    uart_receiver_fsm #(
        .CLK_HZ    (50000000),
        .BIT_9600  (B9600),
        .BIT_19200 (B19200),
        .BIT_38400 (B38400),
        .BIT_57600 (B57600),
        .BIT_115200(B115200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Rxi      (Rxi),
        .BC       (BC),
        .PbitEna  (PbitEna),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .ParityErr(ParityErr),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bl_of(input logic [2:0] bc);
        case (bc)
            3'b001:  return B19200;
            3'b010:  return B38400;
            3'b011:  return B57600;
            3'b100:  return B115200;
            default: return B9600;
        endcase
    endfunction

    // Strobe monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (RxValid) begin
            if (prev_valid) check("valid_two_cycles", 32'(prev_valid), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(RxData), 32'hffff_ffff);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                check("rx_data", 32'(RxData), 32'(e[9:2]));
                check("parity_err", 32'(ParityErr), 32'(e[1]));
                check("frame_err", 32'(FrameErr), 32'(e[0]));
            end
        end
        prev_valid = RxValid;
    end

    // Drives one frame: start, 8 data bits, optional slot bit, one stop bit.
    // abort_at pulses rst mid-bit of that frame bit; flip_at moves BC to 100 at that bit.
    task automatic send(input logic [7:0] d, input bit slot, input logic pv, input logic sv,
                        input int abort_at, input int flip_at);
        int   bl;
        logic bits[$];
        bl = bl_of(BC);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (slot) bits.push_back(pv);
        bits.push_back(sv);
        for (int i = 0; i < bits.size(); i++) begin
            Rxi = bits[i];
            if (i == flip_at) BC = 3'b100;
            for (int c = 0; c < bl; c++) begin
                @(negedge clk);
                if (i == abort_at && c == bl / 2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("abort_rxdata", 32'(RxData), 32'h0);
                    check("abort_valid", 32'(RxValid), 32'h0);
                    check("abort_perr", 32'(ParityErr), 32'h0);
                    check("abort_ferr", 32'(FrameErr), 32'h0);
                    check("abort_busy", 32'(Busy), 32'h0);
                    Rxi = 1'b1;
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
        end
        Rxi = 1'b1;
    endtask

    // Transmitter-style frame: the slot is always sent, 1 when parity is off.
    task automatic tx(input logic [7:0] d);
        sb.push_back({d, 2'b00});
        send(d, 1'b1, PbitEna ? ^d : 1'b1, 1'b1, -1, -1);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; Rxi = 1'b1; BC = 3'b100; PbitEna = 1'b1;
        idle(3);
        check("rst_rxdata", 32'(RxData), 32'h0);
        check("rst_valid", 32'(RxValid), 32'h0);
        check("rst_perr", 32'(ParityErr), 32'h0);
        check("rst_ferr", 32'(FrameErr), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        rst = 1'b0;
        idle(5);

        // Good frame with parity.
        sb.push_back({8'hA5, 2'b00});
        send(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1);
        drain("a5_strobe", 4 * B115200);
        idle(2);
        check("a5_busy_after", 32'(Busy), 32'h0);

        // Forced-wrong parity bit.
        sb.push_back({8'h01, 2'b10});
        send(8'h01, 1'b1, 1'b0, 1'b1, -1, -1);
        drain("perr_strobe", 4 * B115200);
        idle(2 * B115200);

        // 9600, no parity, back-to-back with one stop bit; BC moved mid second frame.
        BC = 3'b000; PbitEna = 1'b0;
        sb.push_back({8'h3C, 2'b00});
        sb.push_back({8'hC3, 2'b00});
        send(8'h3C, 1'b0, 1'b0, 1'b1, -1, -1);
        send(8'hC3, 1'b0, 1'b0, 1'b1, -1, 4);
        drain("b2b_strobes", 4 * B9600);
        idle(2 * B9600);

        // False start: short low glitch.
        BC = 3'b100;
        Rxi = 1'b0;
        idle(B115200 / 4);
        Rxi = 1'b1;
        idle(B115200 / 2 + 3);
        check("false_start_busy", 32'(Busy), 32'h0);
        idle(12 * B115200);
        check("false_start_nostrobe", 32'(sb.size()), 32'd0);

        // Break: line low for 20 bit times.
        sb.push_back({8'h00, 2'b01});
        Rxi = 1'b0;
        idle(15 * B115200);
        check("break_strobe", 32'(sb.size()), 32'd0);
        check("break_busy_low", 32'(Busy), 32'h1);
        idle(5 * B115200);
        check("break_busy_end", 32'(Busy), 32'h1);
        Rxi = 1'b1;
        idle(5);
        check("break_busy_release", 32'(Busy), 32'h0);
        sb.push_back({8'h55, 2'b00});
        send(8'h55, 1'b0, 1'b0, 1'b1, -1, -1);
        drain("after_break", 4 * B115200);
        idle(2 * B115200);

        // Reset in data bit 4 of 0xFF, then a clean 0x81.
        BC = 3'b011; PbitEna = 1'b1;
        send(8'hFF, 1'b1, 1'b0, 1'b1, 5, -1);
        idle(12 * B57600);
        check("abort_nostrobe", 32'(sb.size()), 32'd0);
        sb.push_back({8'h81, 2'b00});
        send(8'h81, 1'b1, 1'b0, 1'b1, -1, -1);
        drain("after_abort", 4 * B57600);
        idle(2 * B57600);

        // Loopback: full sweep at 115200, parity toggling; spot values at other rates.
        BC = 3'b100;
        for (int v = 0; v < 256; v++) begin
            PbitEna = v[0];
            tx(8'(v));
        end
        drain("sweep_115200", 4 * B115200);
        for (int b = 0; b < 4; b++) begin
            idle(2 * B9600);
            BC = 3'(b);
            PbitEna = b[0];
            tx(8'h00);
            tx(8'hFF);
            tx(8'($urandom_range(0, 255)));
            tx(8'($urandom_range(0, 255)));
            drain("sweep_rate", 4 * bl_of(BC));
        end
        idle(2 * B9600);
        check("end_busy", 32'(Busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver_fsm.md
Name: uart_receiver_fsm

Overview:
- Serial-to-parallel UART receive stage that consumes the Txo line produced by UARTTransmitter.
- Decodes the frame: start, 8 data bits LSB first, optional parity slot, stop.
- Uses the same 50 MHz clk and the same BC baud-select encoding.
- Delivers each byte with a one-cycle valid strobe and parity/framing error flags.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documents the bit-period constants below.
- BIT_9600, 5208, clk cycles per bit at 9600 baud.
- BIT_19200, 2604, clk cycles per bit at 19200 baud.
- BIT_38400, 1302, clk cycles per bit at 38400 baud.
- BIT_57600, 868, clk cycles per bit at 57600 baud.
- BIT_115200, 434, clk cycles per bit at 115200 baud.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  asynchronous, active-high reset.
- Rxi  input  1  serial line in, asynchronous to clk, idle high.
- BC  input  3  baud select: 001=19200, 010=38400, 011=57600, 100=115200, any other value=9600.
- PbitEna  input  1  high = frame carries an even-parity bit after D7.
- RxData  output  8  last received byte.
- RxValid  output  1  one-cycle strobe: RxData and the error flags are updated.
- ParityErr  output  1  parity mismatch on last frame; 0 when parity is disabled.
- FrameErr  output  1  stop bit sampled low on last frame.
- Busy  output  1  high from start detect until return to IDLE.

Behaviour:
- Reset (async, rst=1):
  - RxData=8'h00, RxValid=0, ParityErr=0, FrameErr=0, Busy=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input path: Rxi passes through a 2-FF synchronizer; all decisions use the second flop (rxs).
- Bit length BitLen is selected from BC and latched together with PbitEna at start detect. BC/PbitEna changes mid-frame have no effect.
- Bit counter is 13 bits wide; half-bit = BitLen>>1.
- States:
  - IDLE: rxs==0 -> START, clear counter, Busy=1.
  - START: after half-bit cycles, resample rxs.
    - rxs==1 -> false start -> IDLE, no strobe.
    - rxs==0 -> DATA, counter cleared, bit index=0.
  - DATA: every BitLen cycles, sample rxs into shift bit [index], LSB first. After index 7 -> PARITY if PbitEna latched, else STOP.
  - PARITY: after BitLen cycles, sample p. perr = p ^ (^data); even parity, matching transmitter Pbit = ^UI. -> STOP.
  - STOP: after BitLen cycles, sample rxs. Then:
    - Register RxData, ParityErr (perr, or 0 if parity disabled), FrameErr = ~rxs.
    - Pulse RxValid for exactly one clk, on the edge after the stop sample.
    - Good stop -> IDLE. Bad stop -> WAIT_HIGH.
  - WAIT_HIGH: Busy=1; stay until rxs==1, then -> IDLE. No start detection while the line is held low (break).
- Returning to IDLE at mid-stop-bit allows back-to-back frames with one stop bit.
- Outputs hold between strobes; RxValid is never high for two consecutive cycles.
- Latency: Rxi falling edge to RxValid = 2 (sync) + half + 9×BitLen (+BitLen with parity) + 1 clk, ±1 clk.
- Transmitter compatibility: with PbitEna=0 the transmitter puts 1 in the parity slot; the receiver treats it as stop/idle.
- Reset asserted mid-frame aborts immediately with no strobe. After release, the receiver waits in IDLE for the next falling edge.

Test Plan:
- BC=100, PbitEna=1, send 0xA5 (parity 0) with ideal 434-clk bits -> one RxValid, RxData=A5, ParityErr=0, FrameErr=0, Busy low afterward.
- BC=100, PbitEna=1, send 0x01 with parity bit forced 0 (correct is 1) -> RxData=01, ParityErr=1, FrameErr=0.
- BC=000 (5208 clk/bit), PbitEna=0, send 0x3C then 0xC3 back-to-back with one stop bit each -> two strobes, 3C then C3, no errors. Change BC to 100 mid-frame -> no effect.
- BC=100, Rxi low for 100 clk then high -> false start: no RxValid, Busy returns 0 within half-bit+3 clk.
- BC=100, Rxi held low for 20 bit times -> one strobe with RxData=00 and FrameErr=1, Busy stays 1 until Rxi high. A following 0x55 frame is received correctly.
- BC=011, PbitEna=1, assert rst during data bit 4 of 0xFF -> outputs at reset values, no strobe. Next frame 0x81 decodes correctly.
- Loopback: UARTTransmitter Txo drives Rxi, same BC/PbitEna, UI sweeps all 256 values at each BC setting -> RxData==UI on every strobe, both error flags 0.
